// File: rtl/data_memory_ws.sv
// Multi-cycle word-addressed data memory with programmable wait states and ready/busy handshake.
// Optional DMEM_ALIGN_CHECK_EN rejects misaligned or out-of-range byte addresses.
module data_memory_ws #(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int DATAWIDTH_ADDR = 10,
  parameter int WAIT_STATES    = 2
) (
  input  logic                     DataMemoryWS_CLOCK_50,
  input  logic                     DataMemoryWS_RESET_InLow,
  input  logic                     DataMemoryWS_Selector_RD,
  input  logic                     DataMemoryWS_Selector_WR,
  input  logic [DATAWIDTH_BUS-1:0] DataMemoryWS_Address_In,
  input  logic [DATAWIDTH_BUS-1:0] DataMemoryWS_Data_In,
  output logic [DATAWIDTH_BUS-1:0] DataMemoryWS_Data_Out,
  output logic                     DataMemoryWS_Ready_Out,
  output logic                     DataMemoryWS_Busy_Out,
  output logic                     DataMemoryWS_Error_Out
);

  localparam int DEPTH = 1 << DATAWIDTH_ADDR;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t state, state_next;

  logic [3:0]                count;
  logic [DATAWIDTH_ADDR-1:0] idx_q;
  logic [DATAWIDTH_BUS-1:0]  wdata_q;
  logic                      op_wr_q;
  logic                      reject_q;
  logic [DATAWIDTH_BUS-1:0]  mem [DEPTH];

  logic req;
  logic reject;
  logic access;

  assign req    = DataMemoryWS_Selector_RD | DataMemoryWS_Selector_WR;
  assign access = (state == S_WAIT) && (count == 4'd0);

`ifdef DMEM_ALIGN_CHECK_EN
  assign reject = (DataMemoryWS_Selector_RD && DataMemoryWS_Selector_WR)
               || (DataMemoryWS_Address_In[1:0] != 2'b00)
               || ((DataMemoryWS_Address_In >> (DATAWIDTH_ADDR + 2)) != '0);
`else
  // Low byte-offset bits and bits above the depth are deliberately ignored (address wraps).
  logic unused_addr_bits;
  assign unused_addr_bits = ^DataMemoryWS_Address_In;
  assign reject = DataMemoryWS_Selector_RD && DataMemoryWS_Selector_WR;
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req) state_next = S_WAIT;
      S_WAIT:  if (count == 4'd0) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge DataMemoryWS_CLOCK_50 or negedge DataMemoryWS_RESET_InLow) begin
    if (!DataMemoryWS_RESET_InLow) begin
      state                  <= S_IDLE;
      count                  <= 4'd0;
      idx_q                  <= '0;
      wdata_q                <= '0;
      op_wr_q                <= 1'b0;
      reject_q               <= 1'b0;
      DataMemoryWS_Data_Out  <= '0;
      DataMemoryWS_Error_Out <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && req) begin
        count                  <= 4'(WAIT_STATES);
        idx_q                  <= DataMemoryWS_Address_In[DATAWIDTH_ADDR+1:2];
        wdata_q                <= DataMemoryWS_Data_In;
        op_wr_q                <= DataMemoryWS_Selector_WR;
        reject_q               <= reject;
        DataMemoryWS_Error_Out <= 1'b0;
      end else if (state == S_WAIT && count != 4'd0) begin
        count <= count - 4'd1;
      end
      if (access) begin
        if (!op_wr_q && !reject_q)
          DataMemoryWS_Data_Out <= mem[idx_q];
        DataMemoryWS_Error_Out <= reject_q;
      end
    end
  end

  // Write enable is derived from state, so a reset mid-access can never commit the write.
  always_ff @(posedge DataMemoryWS_CLOCK_50) begin
    if (access && op_wr_q && !reject_q)
      mem[idx_q] <= wdata_q;
  end

  assign DataMemoryWS_Ready_Out = (state == S_DONE);
  assign DataMemoryWS_Busy_Out  = (state != S_IDLE);

endmodule

// File: tb/tb_data_memory_ws.sv
// Self-checking bench: table vectors and randomized accesses for WAIT_STATES=2, plus a WAIT_STATES=0 instance.
module tb_data_memory_ws;

  logic        clk;
  logic        rst_n;
  logic        rd   [2];
  logic        wr   [2];
  logic [31:0] addr [2];
  logic [31:0] din  [2];
  logic [31:0] dout [2];
  logic        rdy  [2];
  logic        busy [2];
  logic        err  [2];

  int total = 0;
  int bad   = 0;

  data_memory_ws #(.DATAWIDTH_BUS(32), .DATAWIDTH_ADDR(10), .WAIT_STATES(2)) dut (
    .DataMemoryWS_CLOCK_50   (clk),
    .DataMemoryWS_RESET_InLow(rst_n),
    .DataMemoryWS_Selector_RD(rd[0]),
    .DataMemoryWS_Selector_WR(wr[0]),
    .DataMemoryWS_Address_In (addr[0]),
    .DataMemoryWS_Data_In    (din[0]),
    .DataMemoryWS_Data_Out   (dout[0]),
    .DataMemoryWS_Ready_Out  (rdy[0]),
    .DataMemoryWS_Busy_Out   (busy[0]),
    .DataMemoryWS_Error_Out  (err[0])
  );

  data_memory_ws #(.DATAWIDTH_BUS(32), .DATAWIDTH_ADDR(10), .WAIT_STATES(0)) dut0 (
    .DataMemoryWS_CLOCK_50   (clk),
    .DataMemoryWS_RESET_InLow(rst_n),
    .DataMemoryWS_Selector_RD(rd[1]),
    .DataMemoryWS_Selector_WR(wr[1]),
    .DataMemoryWS_Address_In (addr[1]),
    .DataMemoryWS_Data_In    (din[1]),
    .DataMemoryWS_Data_Out   (dout[1]),
    .DataMemoryWS_Ready_Out  (rdy[1]),
    .DataMemoryWS_Busy_Out   (busy[1]),
    .DataMemoryWS_Error_Out  (err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One complete handshake on instance 'which'; request raised away from the edge,
  // dropped in the Ready cycle as the requester must.
  task automatic access(input int which, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit exp_err, input bit chk_dout,
                        input logic [31:0] exp_dout, input string name);
    int n;
    int exp_lat;
    exp_lat = (which == 0) ? 4 : 2;
    @(negedge clk);
    rd[which] = r; wr[which] = w; addr[which] = a; din[which] = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) check({name, " busy"}, 32'(busy[which]), 32'd1);
    end while (!rdy[which] && n < 40);
    rd[which] = 1'b0; wr[which] = 1'b0;
    check({name, " latency"}, n, exp_lat);
    check({name, " error"}, 32'(err[which]), 32'(exp_err));
    if (chk_dout) check({name, " data"}, dout[which], exp_dout);
    @(posedge clk); #1;
    check({name, " ready pulse"}, 32'(rdy[which]), 32'd0);
  endtask

  typedef struct {
    bit          r;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    bit          e;
    logic [31:0] q;
  } vec_t;

  vec_t vecs [9];

  logic [31:0] model_mem [int];
  logic [31:0] model_dout;
  bit          model_known;
  bit          align_chk;

  initial begin
`ifdef DMEM_ALIGN_CHECK_EN
    align_chk = 1'b1;
`else
    align_chk = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; din[i] = '0;
    end
    rst_n = 1'b0;
    #22 rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle busy", 32'(busy[0]), 32'd0);
      if (i == 0) begin
        check("reset data", dout[0], 32'd0);
        check("reset ready", 32'(rdy[0]), 32'd0);
        check("reset error", 32'(err[0]), 32'd0);
      end
    end

    vecs[0] = '{1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 32'h8,    32'h55,       1'b0, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b1, 32'h8,    32'h99,       1'b1, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b0, 32'h8,    32'h0,        1'b0, 32'h55};
    vecs[5] = '{1'b0, 1'b1, 32'h0,    32'hCAFE,     1'b0, 32'h55};
    vecs[6] = '{1'b0, 1'b1, 32'h2,    32'h77,       align_chk, 32'h55};
    vecs[7] = '{1'b0, 1'b1, 32'h1000, 32'h1234,     align_chk, 32'h55};
    vecs[8] = '{1'b1, 1'b0, 32'h0,    32'h0,        1'b0, align_chk ? 32'hCAFE : 32'h1234};
    for (int i = 0; i < 9; i++)
      access(0, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].e, 1'b1, vecs[i].q,
             $sformatf("vec%0d", i));

    access(1, 1'b0, 1'b1, 32'h0, 32'h1, 1'b0, 1'b1, 32'h0, "ws0 wr0");
    access(1, 1'b0, 1'b1, 32'h4, 32'h2, 1'b0, 1'b1, 32'h0, "ws0 wr4");
    access(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1, "ws0 rd0");

    access(0, 1'b0, 1'b1, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, "pre 0x20");
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 32'h20; din[0] = 32'hA5A5A5A5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort in wait", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort data", dout[0], 32'd0);
    check("abort busy", 32'(busy[0]), 32'd0);
    check("abort ready", 32'(rdy[0]), 32'd0);
    check("abort error", 32'(err[0]), 32'd0);
    wr[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'h0, "post abort rd");

    // Randomized traffic against a word-array model of the memory.
    model_dout  = 32'h0;
    model_known = 1'b1;
    for (int i = 0; i < 60; i++) begin
      bit          r, w, e;
      logic [31:0] a, d;
      int          k, sel, idx;
      k   = $urandom_range(0, 9);
      r   = (k == 0) || (k >= 5);
      w   = (k < 5);
      a   = 32'($urandom_range(0, 15)) << 2;
      sel = $urandom_range(0, 9);
      if (sel == 0) a = a | 32'($urandom_range(1, 3));
      if (sel == 1) a = a | 32'h1000;
      d   = $urandom;
      idx = int'((a >> 2) % 1024);
      e   = (r && w) || (align_chk && ((a % 4) != 0 || (a >> 12) != 0));
      if (!e && w) model_mem[idx] = d;
      if (!e && r) begin
        model_known = model_mem.exists(idx);
        if (model_known) model_dout = model_mem[idx];
      end
      access(0, r, w, a, d, e, model_known, model_dout, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
